// File: rtl/mem_bus_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_master_if
//  Description : Handshake and memory-port bundle for mem_bus_master.
//                Request side (req_*) is valid/ready. Response side (resp_*)
//                is valid/ready. The memory side (mem_*) drives a tiny16 memory
//                with a MAR-latched address, write-on-in_en and a
//                combinational read-out.
//                master modport: the bus initiator (mem_bus_master).
//                slave  modport: request source, response sink and memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_len;

    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        resp_last;

    logic        mem_addr_en;
    logic [15:0] mem_addr;
    logic        mem_in_en;
    logic [15:0] mem_in;
    logic        mem_out_en;
    logic [15:0] mem_out;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_len, resp_ready, mem_out,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_last,
               mem_addr_en, mem_addr, mem_in_en, mem_in, mem_out_en
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_len, resp_ready, mem_out,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_last,
               mem_addr_en, mem_addr, mem_in_en, mem_in, mem_out_en
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_master
//  Description : Bus initiator for the tiny16 memory port. It turns one
//                valid/ready word request into the sequence "load MAR, then
//                write or read" and returns one response beat per access.
//                There is never more than one request outstanding.
//  Ports       : clk  - system clock, all state changes on posedge
//                rst  - synchronous active-high reset
//                bus  - mem_bus_master_if.master (req_*, resp_*, mem_*)
//  Parameters  : MEM_SIZE - words in the attached memory. An address at or
//                above MEM_SIZE gets an error response with no bus access.
//  Config      : MEM_BURST_EN - when defined, a read issues req_len+1 beats
//                at consecutive addresses (wrapping at 16'hFFFF). When it is
//                undefined, every request is a single beat.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_bus_master #(
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    mem_bus_master_if.master        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  beats_q, beats_d;      // beats still to issue after the current one
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic        last_q, last_d;
    logic [15:0] rdata_q, rdata_d;

    logic [1:0]  w_req_beats;
    logic [15:0] w_next_addr;

`ifdef MEM_BURST_EN
    // Writes are always a single beat. Only reads use the burst length.
    assign w_req_beats = bus.req_we ? 2'd0 : bus.req_len;
`else
    assign w_req_beats = 2'd0;
`endif

    // The increment wraps 16'hFFFF -> 16'h0000.
    assign w_next_addr = addr_q + 16'd1;

    function automatic logic f_out_of_range(input logic [15:0] a);
        return 32'(a) >= MEM_SIZE;
    endfunction

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        beats_d  = beats_q;
        rvalid_d = rvalid_q;
        err_d    = err_q;
        last_d   = last_q;
        rdata_d  = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    beats_d = w_req_beats;
                    if (f_out_of_range(bus.req_addr)) begin
                        // Skip the bus entirely and answer with an error.
                        state_d  = S_RESP;
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                        rdata_d  = 16'h0000;
                        last_d   = (w_req_beats == 2'd0);
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                // The read data is valid during this cycle only, so capture it at the edge.
                state_d  = S_RESP;
                rvalid_d = 1'b1;
                err_d    = 1'b0;
                last_d   = (beats_q == 2'd0);
                rdata_d  = we_q ? 16'h0000 : bus.mem_out;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    rvalid_d = 1'b0;
                    err_d    = 1'b0;
                    last_d   = 1'b0;
                    rdata_d  = 16'h0000;
                    if (beats_q == 2'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = w_next_addr;
                        beats_d = beats_q - 2'd1;
                        if (f_out_of_range(w_next_addr)) begin
                            // Out-of-range beat inside a burst: error beat, burst continues.
                            state_d  = S_RESP;
                            rvalid_d = 1'b1;
                            err_d    = 1'b1;
                            last_d   = (beats_q == 2'd1);
                        end else begin
                            state_d = S_ADDR;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            beats_q  <= 2'd0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            last_q   <= 1'b0;
            rdata_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            beats_q  <= beats_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            last_q   <= last_d;
            rdata_q  <= rdata_d;
        end
    end

    // The strobes decode straight from the state. That keeps at most one strobe
    // high at a time. The data buses stay at zero while their strobe is low.
    assign bus.req_ready   = (state_q == S_IDLE) && !rst;
    assign bus.mem_addr_en = (state_q == S_ADDR);
    assign bus.mem_addr    = bus.mem_addr_en ? addr_q : 16'h0000;
    assign bus.mem_in_en   = (state_q == S_DATA) && we_q;
    assign bus.mem_in      = bus.mem_in_en ? wdata_q : 16'h0000;
    assign bus.mem_out_en  = (state_q == S_DATA) && !we_q;

    assign bus.resp_valid  = rvalid_q;
    assign bus.resp_err    = err_q;
    assign bus.resp_last   = last_q;
    assign bus.resp_rdata  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_master
//  Description : Self-checking bench for mem_bus_master. A transaction-level
//                model tracks the outstanding request, its beat list, the
//                cycle offset inside each beat, and a shadow copy of memory.
//                Every cycle, the DUT outputs are compared against what that
//                model says must be visible. Directed scenarios pin the model
//                with literal values. Randomized traffic follows them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_bus_master;
    localparam int MEM_SIZE = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_master_if bus();

    mem_bus_master #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- attached memory (MAR + array) ----------------
    logic [15:0] slave_mem [0:255];
    logic [15:0] mar;
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [15:0] pre_val;

    always @(posedge clk) begin
        if (pre_en)               slave_mem[pre_idx] <= pre_val;
        else if (bus.mem_in_en)   slave_mem[mar[7:0]] <= bus.mem_in;
        if (bus.mem_addr_en)      mar <= bus.mem_addr;
    end
    assign bus.mem_out = slave_mem[mar[7:0]];

    // ---------------- stimulus values for the next edge ----------------
    logic        s_valid, s_we, s_rready, s_rst;
    logic [15:0] s_addr, s_wdata;
    logic [1:0]  s_len;

    // ---------------- behavioural model ----------------
    logic [15:0] ref_mem [0:255];
    logic        m_busy, m_we, m_err;
    logic [15:0] m_addr, m_wdata;
    int          m_left;   // beats remaining after the current one
    int          m_j;      // 1 = first cycle after the beat's start edge

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic oor(input logic [15:0] a);
        return int'(a) >= MEM_SIZE;
    endfunction

    // Compare everything the model says must be visible in the current cycle.
    task automatic compare_outputs();
        logic e_ready, e_aen, e_ien, e_oen, e_rv;
        e_ready = !m_busy && !rst;
        e_aen = 1'b0; e_ien = 1'b0; e_oen = 1'b0; e_rv = 1'b0;
        if (m_busy) begin
            if (m_err)          e_rv = 1'b1;
            else if (m_j == 1)  e_aen = 1'b1;
            else if (m_j == 2)  begin e_ien = m_we; e_oen = !m_we; end
            else                e_rv = 1'b1;
        end
        chk("req_ready",   32'(bus.req_ready),   32'(e_ready));
        chk("mem_addr_en", 32'(bus.mem_addr_en), 32'(e_aen));
        chk("mem_in_en",   32'(bus.mem_in_en),   32'(e_ien));
        chk("mem_out_en",  32'(bus.mem_out_en),  32'(e_oen));
        chk("resp_valid",  32'(bus.resp_valid),  32'(e_rv));
        if (e_aen) chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        if (e_ien) chk("mem_in",   32'(bus.mem_in),   32'(m_wdata));
        if (e_rv) begin
            chk("resp_err",   32'(bus.resp_err),   32'(m_err));
            chk("resp_last",  32'(bus.resp_last),  32'(m_left == 0));
            chk("resp_rdata", 32'(bus.resp_rdata),
                (m_err || m_we) ? 32'h0 : 32'(ref_mem[m_addr[7:0]]));
        end
    endtask

    // Advance the model across the coming edge, using the inputs now applied.
    task automatic model_edge();
        if (rst) begin
            if (m_busy && !m_err && m_j == 2 && m_we) ref_mem[m_addr[7:0]] = m_wdata;
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (bus.req_valid) begin
                m_busy  = 1'b1;
                m_we    = bus.req_we;
                m_addr  = bus.req_addr;
                m_wdata = bus.req_wdata;
                m_err   = oor(bus.req_addr);
                m_j     = 1;
`ifdef MEM_BURST_EN
                m_left  = bus.req_we ? 0 : int'(bus.req_len);
`else
                m_left  = 0;
`endif
            end
        end else begin
            if (!m_err && m_j == 2 && m_we) ref_mem[m_addr[7:0]] = m_wdata;
            if (m_err || m_j >= 3) begin
                if (bus.resp_ready) begin
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                    end else begin
                        m_addr = m_addr + 16'd1;
                        m_left = m_left - 1;
                        m_err  = oor(m_addr);
                        m_j    = 1;
                    end
                end
            end else begin
                m_j = m_j + 1;
            end
        end
    endtask

    // One clock cycle: check, apply inputs, predict, then cross the edge.
    task automatic tick();
        compare_outputs();
        bus.req_valid  = s_valid;
        bus.req_we     = s_we;
        bus.req_addr   = s_addr;
        bus.req_wdata  = s_wdata;
        bus.req_len    = s_len;
        bus.resp_ready = s_rready;
        rst            = s_rst;
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a request for one edge. The caller must know the DUT is idle.
    task automatic issue(input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [1:0] len);
        s_valid = 1'b1; s_we = we; s_addr = addr; s_wdata = wdata; s_len = len;
        tick();
        s_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0; s_len = '0;
        s_rready = 1'b1; s_rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_len = '0; bus.resp_ready = 1'b1;
        pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        m_busy = 1'b0; m_we = 1'b0; m_err = 1'b0; m_addr = '0; m_wdata = '0;
        m_left = 0; m_j = 0;

        // Preload the memory while reset is held.
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            pre_en  = 1'b1;
            pre_idx = 8'(i);
            pre_val = 16'($urandom);
            ref_mem[i] = pre_val;
            @(negedge clk);
        end
        pre_en = 1'b0;

        // Reset state
        chk("rst_req_ready",  32'(bus.req_ready),  32'h0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_resp_err",   32'(bus.resp_err),   32'h0);
        chk("rst_resp_last",  32'(bus.resp_last),  32'h0);
        chk("rst_resp_rdata", 32'(bus.resp_rdata), 32'h0);
        chk("rst_strobes",    32'({bus.mem_addr_en, bus.mem_in_en, bus.mem_out_en}), 32'h0);
        chk("rst_mem_addr",   32'(bus.mem_addr),   32'h0);
        chk("rst_mem_in",     32'(bus.mem_in),     32'h0);
        s_rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(bus.req_ready), 32'h1);

        // 1: write 16'h1234 @0x0010
        issue(1'b1, 16'h0010, 16'h1234, 2'd0);
        chk("t1_addr_en",   32'(bus.mem_addr_en), 32'h1);
        chk("t1_mem_addr",  32'(bus.mem_addr),    32'h0010);
        chk("t1_req_ready", 32'(bus.req_ready),   32'h0);
        tick();
        chk("t1_in_en",     32'(bus.mem_in_en),   32'h1);
        chk("t1_mem_in",    32'(bus.mem_in),      32'h1234);
        tick();
        chk("t1_ack",       32'({bus.resp_valid, bus.resp_err, bus.resp_last}), 32'b101);
        chk("t1_rdata",     32'(bus.resp_rdata),  32'h0);
        tick();
        chk("t1_idle_ready", 32'(bus.req_ready),  32'h1);
        chk("t1_mem_word",   32'(slave_mem[16]),  32'h1234);

        // 2: read back @0x0010
        issue(1'b0, 16'h0010, 16'h0, 2'd0);
        tick();
        chk("t2_out_en",    32'(bus.mem_out_en),  32'h1);
        tick();
        chk("t2_rdata",     32'(bus.resp_rdata),  32'h1234);
        chk("t2_err",       32'(bus.resp_err),    32'h0);
        tick();

        // 3: out-of-range read
        issue(1'b0, 16'h0100, 16'h0, 2'd0);
        chk("t3_valid_err", 32'({bus.resp_valid, bus.resp_err, bus.resp_last}), 32'b111);
        chk("t3_rdata",     32'(bus.resp_rdata),  32'h0);
        chk("t3_strobes",   32'({bus.mem_addr_en, bus.mem_in_en, bus.mem_out_en}), 32'h0);
        tick();
        chk("t3_ready",     32'(bus.req_ready),   32'h1);

        // 4: response held back for 5 cycles
        s_rready = 1'b0;
        issue(1'b0, 16'h0010, 16'h0, 2'd0);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", 32'(bus.resp_valid), 32'h1);
            chk("t4_hold_rdata", 32'(bus.resp_rdata), 32'h1234);
            chk("t4_hold_ready", 32'(bus.req_ready),  32'h0);
            tick();
        end
        s_rready = 1'b1;
        chk("t4_still_valid", 32'(bus.resp_valid), 32'h1);
        tick();
        chk("t4_released",    32'({bus.resp_valid, bus.req_ready}), 32'b01);

        // 5: reset during the ADDR cycle of a read
        issue(1'b0, 16'h0010, 16'h0, 2'd0);
        chk("t5_addr_phase", 32'(bus.mem_addr_en), 32'h1);
        s_rst = 1'b1;
        tick();
        chk("t5_no_resp",    32'(bus.resp_valid), 32'h0);
        chk("t5_no_strobe",  32'({bus.mem_addr_en, bus.mem_in_en, bus.mem_out_en}), 32'h0);
        s_rst = 1'b0;
        tick();
        chk("t5_ready_back", 32'(bus.req_ready), 32'h1);
        issue(1'b0, 16'h0010, 16'h0, 2'd0);
        tick();
        tick();
        chk("t5_next_read",  32'({bus.resp_valid, bus.resp_rdata}), {15'h0, 1'b1, 16'h1234});
        tick();

        // 6: read at 0x00FE with len=2 after planting A/B
        issue(1'b1, 16'h00FE, 16'hAAAA, 2'd0); tick(); tick(); tick();
        issue(1'b1, 16'h00FF, 16'hBBBB, 2'd0); tick(); tick(); tick();
        issue(1'b0, 16'h00FE, 16'h0, 2'd2);
        tick();
        tick();
`ifdef MEM_BURST_EN
        chk("t6_b0", 32'({bus.resp_err, bus.resp_last, bus.resp_rdata}), {14'h0, 2'b00, 16'hAAAA});
        tick(); tick(); tick();
        chk("t6_b1", 32'({bus.resp_err, bus.resp_last, bus.resp_rdata}), {14'h0, 2'b00, 16'hBBBB});
        tick();
        chk("t6_b2", 32'({bus.resp_valid, bus.resp_err, bus.resp_last, bus.resp_rdata}),
            {13'h0, 3'b111, 16'h0000});
        tick();
`else
        chk("t6_single", 32'({bus.resp_err, bus.resp_last, bus.resp_rdata}), {14'h0, 2'b01, 16'hAAAA});
        tick();
`endif
        chk("t6_done", 32'(bus.req_ready), 32'h1);

        // Randomized traffic, including resets, out-of-range and wrap addresses.
        for (int n = 0; n < 4000; n++) begin
            s_rst    = ($urandom_range(0, 249) == 0);
            s_valid  = ($urandom_range(0, 3) != 0);
            s_we     = ($urandom_range(0, 2) == 0);
            s_wdata  = 16'($urandom);
            s_len    = 2'($urandom);
            s_rready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 9))
                0:       s_addr = 16'h0100 + 16'($urandom_range(0, 15));
                1:       s_addr = 16'hFFFE + 16'($urandom_range(0, 1));
                2:       s_addr = 16'h00FC + 16'($urandom_range(0, 3));
                default: s_addr = 16'($urandom_range(0, 255));
            endcase
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
